// File: rtl/seq_divider_n.sv
// seq_divider_n: multi-cycle restoring divider for unsigned operands.
// One quotient bit is resolved per clock, giving WIDTH CALC cycles per
// nonzero-divisor operation. A divide-by-zero skips CALC entirely and
// reports error=1 with zero quotient and remainder.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      request; only sampled while IDLE
//   dividend   unsigned A, captured on accepted start
//   divisor    unsigned B, captured on accepted start
//   busy       high during every CALC cycle
//   done       one-cycle pulse in FIN when results become valid
//   quotient   floor(A/B), registered, held until the next FIN
//   remainder  A mod B, registered, held until the next FIN
//   error      last completed operation had a zero divisor
module seq_divider_n #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             error
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;      // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] b_q, b_d;      // latched divisor
   logic [WIDTH:0]   r_q, r_d;      // partial remainder, one extra bit so the compare never wraps
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             err_q, err_d;

   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   r_sub;
   logic             ge;
   logic [CW-1:0]    cnt_dec;

   always_comb begin
      r_sh    = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
      r_sub   = r_sh - {1'b0, b_q};
      ge      = (r_sh >= {1'b0, b_q});
      cnt_dec = cnt_q - 1'b1;

      state_d = state_q;
      q_d     = q_q;
      b_d     = b_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  q_d     = dividend;
                  b_d     = divisor;
                  r_d     = '0;
                  cnt_d   = CW'(WIDTH);
                  busy_d  = 1'b1;
                  state_d = CALC;
               end else begin
                  // Zero divisor: results are known immediately.
                  quot_d  = '0;
                  rem_d   = '0;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = FIN;
               end
            end
         end
         CALC: begin
            r_d   = ge ? r_sub : r_sh;
            q_d   = {q_q[WIDTH-2:0], ge};
            cnt_d = cnt_dec;
            if (cnt_dec == '0) begin
               // Publish on the final iteration so outputs never see partial values.
               quot_d  = {q_q[WIDTH-2:0], ge};
               rem_d   = r_d[WIDTH-1:0];
               err_d   = 1'b0;
               done_d  = 1'b1;
               state_d = FIN;
            end else begin
               busy_d = 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         q_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         b_q     <= b_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign error     = err_q;

endmodule

// File: tb/tb_seq_divider_n.sv
// Scoreboard bench for seq_divider_n: a WIDTH=4 and a WIDTH=8 instance.
// Drivers push expected results (plain / and % arithmetic) plus the
// expected done cycle; per-instance monitors pop and compare on done and
// check that outputs hold their last value between results.
module tb_seq_divider_n;

   typedef struct {
      int q;
      int r;
      int err;
      int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst4, rst8, start4, start8;
   logic [3:0] a4, b4;
   logic [7:0] a8, b8;
   logic       busy4, done4, err4, busy8, done8, err8;
   logic [3:0] quot4, rem4;
   logic [7:0] quot8, rem8;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   exp_t q4[$];
   exp_t q8[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_divider_n #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst4), .start(start4), .dividend(a4), .divisor(b4),
      .busy(busy4), .done(done4), .quotient(quot4), .remainder(rem4), .error(err4));

   seq_divider_n #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst8), .start(start8), .dividend(a8), .divisor(b8),
      .busy(busy8), .done(done8), .quotient(quot8), .remainder(rem8), .error(err8));

   task automatic chk(input string nm, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d expected=%0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic exp_t ref_div(input int a, input int b, input int acc, input int w);
      exp_t e;
      if (b == 0) begin
         e.q = 0; e.r = 0; e.err = 1; e.cyc = acc;
      end else begin
         e.q = a / b; e.r = a % b; e.err = 0; e.cyc = acc + w;
      end
      return e;
   endfunction

   task automatic chk_done(input string tag, input exp_t e, input int q, input int r,
                           input int er, input int bc, input int w);
      chk({tag, "_quot"}, q, e.q);
      chk({tag, "_rem"}, r, e.r);
      chk({tag, "_err"}, er, e.err);
      chk({tag, "_done_cycle"}, cyc, e.cyc);
      chk({tag, "_busy_cycles"}, bc, e.err ? 0 : w);
   endtask

   // Monitors
   exp_t hold4 = '{0, 0, 0, 0};
   exp_t hold8 = '{0, 0, 0, 0};
   int   bc4 = 0;
   int   bc8 = 0;

   always @(negedge clk) begin
      exp_t e;
      if (rst4) begin
         bc4 = 0; hold4 = '{0, 0, 0, 0};
      end else begin
         if (busy4) bc4++;
         if (done4) begin
            if (q4.size() == 0) chk("w4_unexpected_done", 1, 0);
            else begin
               e = q4.pop_front();
               chk_done("w4", e, int'(quot4), int'(rem4), int'(err4), bc4, 4);
               hold4 = e;
            end
            bc4 = 0;
         end else if ({quot4, rem4, err4} !== {hold4.q[3:0], hold4.r[3:0], hold4.err[0]}) begin
            chk("w4_hold", int'({quot4, rem4, err4}), int'({hold4.q[3:0], hold4.r[3:0], hold4.err[0]}));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst8) begin
         bc8 = 0; hold8 = '{0, 0, 0, 0};
      end else begin
         if (busy8) bc8++;
         if (done8) begin
            if (q8.size() == 0) chk("w8_unexpected_done", 1, 0);
            else begin
               e = q8.pop_front();
               chk_done("w8", e, int'(quot8), int'(rem8), int'(err8), bc8, 8);
               hold8 = e;
            end
            bc8 = 0;
         end else if ({quot8, rem8, err8} !== {hold8.q[7:0], hold8.r[7:0], hold8.err[0]}) begin
            chk("w8_hold", int'({quot8, rem8, err8}), int'({hold8.q[7:0], hold8.r[7:0], hold8.err[0]}));
         end
      end
   end

   // Drivers: wait for IDLE (neither busy nor done), then present one start.
   task automatic issue4(input logic [3:0] a, input logic [3:0] b);
      forever begin
         @(negedge clk);
         if (!busy4 && !done4) break;
      end
      a4 = a; b4 = b; start4 = 1'b1;
      @(posedge clk); #1;
      q4.push_back(ref_div(int'(a), int'(b), cyc, 4));
      start4 = 1'b0;
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b);
      forever begin
         @(negedge clk);
         if (!busy8 && !done8) break;
      end
      a8 = a; b8 = b; start8 = 1'b1;
      @(posedge clk); #1;
      q8.push_back(ref_div(int'(a), int'(b), cyc, 8));
      start8 = 1'b0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] ra, rb;
      rst4 = 1'b1; rst8 = 1'b1; start4 = 1'b0; start8 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
      repeat (3) @(posedge clk);
      #1 rst4 = 1'b0; rst8 = 1'b0;
      chk("reset_w4_outputs", int'({busy4, done4, quot4, rem4, err4}), 0);
      chk("reset_w8_outputs", int'({busy8, done8, quot8, rem8, err8}), 0);

      // WIDTH=4 directed cases
      issue4(4'd13, 4'd3);
      issue4(4'd7, 4'd0);
      issue4(4'd15, 4'd1);
      issue4(4'd2, 4'd9);
      issue4(4'd15, 4'd15);

      // Start during CALC must be ignored
      issue4(4'd12, 4'd5);
      @(posedge clk); #1;
      a4 = 4'd9; b4 = 4'd2; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;

      // Reset in the 2nd CALC cycle discards the operation
      issue4(4'd14, 4'd3);
      @(posedge clk); #1;
      rst4 = 1'b1;
      @(posedge clk); #1;
      rst4 = 1'b0;
      void'(q4.pop_back());
      chk("midop_reset_busy", int'(busy4), 0);
      chk("midop_reset_done", int'(done4), 0);
      chk("midop_reset_outputs", int'({quot4, rem4, err4}), 0);
      issue4(4'd14, 4'd3);

      // WIDTH=8
      issue8(8'd200, 8'd7);
      forever begin
         @(negedge clk);
         if (!busy8 && !done8) break;
      end
      // start held high: accepted every WIDTH+2 = 10 cycles
      a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) repeat (9) @(posedge clk);
         @(posedge clk); #1;
         q8.push_back(ref_div(200, 7, cyc, 8));
      end
      start8 = 1'b0;

      // Boundaries then random sweep
      issue8(8'd255, 8'd1);
      issue8(8'd255, 8'd255);
      issue8(8'd0, 8'd0);
      issue8(8'd0, 8'd9);
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         issue8(ra, rb);
      end

      // Drain
      for (int i = 0; i < 40 && (q4.size() != 0 || q8.size() != 0); i++) @(posedge clk);
      repeat (5) @(posedge clk);
      chk("drain_w4", q4.size(), 0);
      chk("drain_w8", q8.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_divider_n.md
Name: seq_divider_n

Overview:
- Parametrised, multi-cycle restoring divider for unsigned operands; successor to the fixed 4-bit combinational divider in the ALU datapath.
- Handles arbitrary divisors at any WIDTH, producing one quotient bit per clock.
- Uses a start/busy/done handshake and flags divide-by-zero.
- Sits beside the adder/multiplier units and is selected by the ALU opcode decoder.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned A; captured on accepted start.
- divisor  input  WIDTH  unsigned B; captured on accepted start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  floor(A/B); registered.
- remainder  output  WIDTH  A mod B; registered.
- error  output  1  divisor was zero for the last completed operation; registered.

Behaviour:
- Reset (one clock, rst high), whether idle or mid-operation:
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, error=0.
  - Internal registers and iteration counter cleared; any in-flight result is discarded.
- States are IDLE, CALC and FIN.
- IDLE:
  - start=1 and divisor≠0: latch operands, clear partial remainder R (WIDTH+1 bits), load counter=WIDTH, go to CALC.
  - start=1 and divisor=0: go to FIN with pending error=1, quotient=0, remainder=0.
  - start=0: stay in IDLE.
- CALC, once per cycle:
  - R = {R[WIDTH-1:0], Q[WIDTH-1]}; Q shifts left by 1.
  - If R ≥ {0,B}: R = R−B and Q[0]=1; otherwise Q[0]=0.
  - Decrement the counter. When the counter reaches 0 after this update, go to FIN.
- FIN (exactly 1 cycle):
  - Assert done=1 and drive quotient/remainder/error from the internal result.
  - Return to IDLE on the next edge.
- Output timing:
  - Outputs hold their values after done drops, until the next FIN.
  - quotient, remainder and error are updated only on the edge entering FIN's output cycle. They must never show partial values.
- busy=1 exactly during CALC cycles (WIDTH cycles).
- Latency:
  - start sampled at edge k.
  - Nonzero divisor: done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after acceptance.
  - Zero divisor: done high in the cycle after edge k (1 cycle).
- start while in CALC or FIN: ignored, not queued. Operand changes during CALC have no effect.
- start held continuously: a new operation is accepted on the first IDLE cycle after FIN, giving back-to-back throughput of one result every WIDTH+2 cycles.
- Arithmetic:
  - Fully unsigned.
  - dividend < divisor → quotient=0, remainder=dividend.
  - divisor=1 → quotient=dividend, remainder=0.
  - Maximum values (all ones / 1) must not overflow. R is WIDTH+1 bits, so the compare never wraps.
- error clears to 0 on the next successful (nonzero-divisor) completion.
- No X propagation on any output after reset.

Test Plan:
- WIDTH=4; reset; A=13, B=3, start pulse → busy for 4 cycles; done pulse 5 cycles after acceptance with quotient=4, remainder=1, error=0; outputs stable afterwards.
- WIDTH=4; A=7, B=0 → done 1 cycle after start, busy never asserted; quotient=0, remainder=0, error=1. Then A=15, B=1 → quotient=15, remainder=0, error=0.
- WIDTH=4; A=2, B=9 → quotient=0, remainder=2. Then A=15, B=15 → quotient=1, remainder=0.
- WIDTH=4; start A=12, B=5; during CALC pulse start with A=9, B=2 → second request ignored; result quotient=2, remainder=2; one done pulse only.
- WIDTH=4; start A=14, B=3; assert rst on the 2nd CALC cycle → next cycle busy=0, done=0, outputs=0, state IDLE. A new start A=14, B=3 → quotient=4, remainder=2.
- WIDTH=8; A=200, B=7 → done 9 cycles after acceptance with quotient=28, remainder=4. Then start held high across 3 operations → done pulses spaced 10 cycles apart. Randomised sweep of 1000 operand pairs checked against a reference model.
